systolic_skew_feeder: RTL and testbench

- Transmit-side counterpart to the tpumac array input.
- Buffers a DIM x DIM block of signed 8-bit operands, then streams them into a systolic row/column with diagonal skew.
- Lane i is delayed i cycles.
- Drives the per-lane operand bus and the en strobe that the MAC cells consume on Ain/Bin.

---
 rtl/systolic_skew_feeder_pkg.sv | 7 +
 rtl/systolic_skew_feeder_skew_lane.sv | 35 +++
 rtl/systolic_skew_feeder.sv | 111 +++++++++++
 tb/tb_systolic_skew_feeder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared parameters and state encoding for the systolic array feeder and MAC array.
package tpu_pkg;
    localparam int unsigned BITS_AB = 8;
    localparam int unsigned DIM     = 8;

    typedef enum logic [1:0] {LOAD, FULL, STREAM, DONE} feeder_state_t;
endpackage

// File: rtl/systolic_skew_feeder_skew_lane.sv
// One lane of the skew feeder: holds its column of the operand block and
// selects element (step - LANE), or zero padding outside the diagonal.
module skew_lane #(
    parameter int unsigned BITS_AB = tpu_pkg::BITS_AB,
    parameter int unsigned DIM     = tpu_pkg::DIM,
    parameter int unsigned LANE    = 0,
    parameter int unsigned CW      = 4,
    parameter int unsigned TW      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [CW-1:0]      wr_idx,
    input  logic [BITS_AB-1:0] wr_data,
    input  logic [TW-1:0]      step,
    output logic [BITS_AB-1:0] sel
);
    logic [BITS_AB-1:0] col [DIM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DIM; k++) col[k] <= '0;
        end else if (wr_en) begin
            for (int unsigned k = 0; k < DIM; k++)
                if (32'(wr_idx) == k) col[k] <= wr_data;
        end
    end

    // Entry k of this column belongs to stream step LANE + k.
    always_comb begin
        sel = '0;
        for (int unsigned k = 0; k < DIM; k++)
            if (32'(step) == LANE + k) sel = col[k];
    end
endmodule

// File: rtl/systolic_skew_feeder.sv
// Buffers a DIM x DIM operand block, then streams it into a systolic edge
// with lane i delayed i cycles; holds the load/stream state machine.
module systolic_skew_feeder
    import tpu_pkg::*;
#(
    parameter int unsigned BITS_AB = tpu_pkg::BITS_AB,
    parameter int unsigned DIM     = tpu_pkg::DIM
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vec_valid,
    input  logic [DIM*BITS_AB-1:0] vec_data,
    output logic                   vec_ready,
    input  logic                   start,
    output logic                   busy,
    output logic [DIM*BITS_AB-1:0] a_out,
    output logic                   en_out,
    output logic                   done
);
    localparam int unsigned CW = $clog2(DIM + 1);
    localparam int unsigned TW = $clog2(2 * DIM - 1);
    localparam logic [CW-1:0] C_LAST = CW'(DIM - 1);
    localparam logic [TW-1:0] T_LAST = TW'(2 * DIM - 2);

    feeder_state_t          state;
    logic [CW-1:0]          count;
    logic [TW-1:0]          t;
    logic [TW-1:0]          step_nxt;
    logic                   accept;
    logic [DIM*BITS_AB-1:0] stream_data;

    assign accept = vec_valid && vec_ready && (state == LOAD);

    // Lanes look one step ahead so a_out can be registered with latency 1.
    always_comb begin
        step_nxt = '0;
        if (state == STREAM) step_nxt = t + 1'b1;
    end

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        skew_lane #(
            .BITS_AB (BITS_AB),
            .DIM     (DIM),
            .LANE    (i),
            .CW      (CW),
            .TW      (TW)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (accept),
            .wr_idx  (count),
            .wr_data (vec_data[i*BITS_AB +: BITS_AB]),
            .step    (step_nxt),
            .sel     (stream_data[i*BITS_AB +: BITS_AB])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            count     <= '0;
            t         <= '0;
            a_out     <= '0;
            en_out    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            vec_ready <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        count <= count + 1'b1;
                        if (count == C_LAST) begin
                            state     <= FULL;
                            vec_ready <= 1'b0;
                        end
                    end
                end
                FULL: begin
                    if (start) begin
                        state  <= STREAM;
                        t      <= '0;
                        busy   <= 1'b1;
                        en_out <= 1'b1;
                        a_out  <= stream_data;
                    end
                end
                STREAM: begin
                    if (t == T_LAST) begin
                        state  <= DONE;
                        en_out <= 1'b0;
                        a_out  <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        t     <= t + 1'b1;
                        a_out <= stream_data;
                    end
                end
                DONE: begin
                    state     <= LOAD;
                    done      <= 1'b0;
                    count     <= '0;
                    t         <= '0;
                    vec_ready <= 1'b1;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (DIM=4): expected skewed steps are
// queued from a reference model when start is driven and popped on en_out.
module tb_systolic_skew_feeder;
    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic           clk;
    logic           rst_n;
    logic           vec_valid;
    logic [D*W-1:0] vec_data;
    logic           vec_ready;
    logic           start;
    logic           busy;
    logic [D*W-1:0] a_out;
    logic           en_out;
    logic           done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] blk [4];
    logic [31:0] exp_q [$];

    systolic_skew_feeder #(
        .BITS_AB (W),
        .DIM     (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vec_valid (vec_valid),
        .vec_data  (vec_data),
        .vec_ready (vec_ready),
        .start     (start),
        .busy      (busy),
        .a_out     (a_out),
        .en_out    (en_out),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_step(input int t);
        logic [31:0] r;
        logic [31:0] v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (t - i >= 0 && t - i < 4) begin
                v = blk[t - i];
                r[i*8 +: 8] = v[i*8 +: 8];
            end
        end
        return r;
    endfunction

    task automatic set_block(input logic [7:0] base);
        for (int v = 0; v < 4; v++)
            for (int i = 0; i < 4; i++)
                blk[v][i*8 +: 8] = base + 8'(v * 4 + i);
    endtask

    task automatic load_vec(input int v);
        chk("load_ready", 32'(vec_ready), 32'd1);
        vec_valid = 1'b1;
        vec_data  = blk[v];
        tick();
        vec_valid = 1'b0;
        vec_data  = '0;
    endtask

    task automatic load_block();
        for (int v = 0; v < 4; v++) load_vec(v);
        chk("full_ready_low", 32'(vec_ready), 32'd0);
    endtask

    task automatic run_stream();
        int  n_en;
        logic got_done;
        logic [31:0] e;
        for (int t = 0; t < 7; t++) exp_q.push_back(model_step(t));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("latency_en", 32'(en_out), 32'd1);
        n_en = 0;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 20 && !got_done; cyc++) begin
            if (en_out) begin
                n_en++;
                chk("stream_busy", 32'(busy), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("extra_en", 32'(en_out), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_data", a_out, e);
                end
            end else if (done) begin
                chk("done_aout", a_out, 32'd0);
                chk("done_busy", 32'(busy), 32'd0);
                got_done = 1'b1;
            end else begin
                chk("idle_aout", a_out, 32'd0);
            end
            tick();
        end
        chk("en_count", 32'(n_en), 32'd7);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("done_seen", 32'(got_done), 32'd1);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("ready_after_done", 32'(vec_ready), 32'd1);
        exp_q.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        vec_valid = 1'b0;
        vec_data  = '0;
        start     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_aout", a_out, 32'd0);
        chk("rst_en", 32'(en_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(vec_ready), 32'd1);

        // Basic block 1..16 with fixed step patterns as a sanity anchor.
        set_block(8'd1);
        chk("model_t3", model_step(3), 32'h04070A0D);
        load_block();
        run_stream();

        // Back-to-back second block loaded right after done.
        set_block(8'h21);
        load_block();
        run_stream();

        // start after a partial load is ignored.
        set_block(8'h41);
        load_vec(0);
        load_vec(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("partial_busy", 32'(busy), 32'd0);
            chk("partial_en", 32'(en_out), 32'd0);
            chk("partial_ready", 32'(vec_ready), 32'd1);
            tick();
        end
        load_vec(2);
        load_vec(3);
        chk("partial_full", 32'(vec_ready), 32'd0);
        run_stream();

        // vec_valid in FULL is dropped.
        set_block(8'h61);
        load_block();
        vec_valid = 1'b1;
        vec_data  = 32'h7F7F7F7F;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("full_hold_ready", 32'(vec_ready), 32'd0);
            chk("full_hold_en", 32'(en_out), 32'd0);
        end
        vec_valid = 1'b0;
        vec_data  = '0;
        run_stream();

        // Negative operands pass through unaltered.
        for (int v = 0; v < 4; v++) blk[v] = 32'h80808080;
        load_block();
        run_stream();

        // Asynchronous reset during stream step t=2.
        set_block(8'hA1);
        load_block();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_rst_step2", a_out, model_step(2));
        #2 rst_n = 1'b0;
        #1;
        chk("async_aout", a_out, 32'd0);
        chk("async_en", 32'(en_out), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(vec_ready), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_rst_start_busy", 32'(busy), 32'd0);
        chk("post_rst_start_en", 32'(en_out), 32'd0);
        set_block(8'hC1);
        load_block();
        run_stream();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
